aes128_cbc_dec_core: RTL and testbench
======================================

Name: aes128_cbc_dec_core

Overview:
Iterative AES-128 CBC decryptor; the receive-side counterpart of the CBC encryptor top. It takes a key and IV on `start` and expands the 11 round keys into a local store. It then decrypts ciphertext blocks one round per cycle and XORs each result with the chaining value (IV, or the previous ciphertext) to produce plaintext. It sits between the ciphertext ingress buffer and the plaintext consumer, with valid/ready handshakes on both sides.

Parameters:
None (AES-128 fixed: Nk=4, Nr=10).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse: capture key/IV, begin key expansion (honoured only in IDLE or READY)
key_0..key_3  input  32 each  cipher key; 128-bit key = {key_3,key_2,key_1,key_0}
vector_0..vector_3  input  32 each  IV; 128-bit IV = {vector_3,...,vector_0}
cipher_text_0..3  input  32 each  ciphertext block, same packing
in_valid  input  1  ciphertext word-set valid
in_ready  output  1  core can accept a ciphertext block
plain_text_0..3  output  32 each  plaintext block, same packing
out_valid  output  1  plaintext valid
out_ready  input  1  consumer accepts plaintext
busy  output  1  high in KEXP, DEC, OUT

Behaviour:
- Byte order: packed 128-bit values are FIPS-197 order; byte 0 = bits [127:120].
- Reset:
  - state=IDLE; in_ready=0, out_valid=0, busy=0.
  - plain_text_*=0; key store, chain and data registers = 0.
  - Reset mid-operation aborts any block; no output is produced.
- States: IDLE, KEXP, READY, DEC, OUT.
- IDLE:
  - in_ready=0.
  - start -> capture rk0=key and chain=IV, rcnt=1, go to KEXP.
- KEXP:
  - One round key per cycle (RotWord/SubWord/Rcon) into rk[rcnt].
  - rcnt 1..10 takes 10 cycles.
  - Start captured at edge T; state=READY and in_ready=1 from cycle T+11.
  - start is ignored in KEXP.
- READY:
  - in_ready=1.
  - in_valid&in_ready at edge A: ct_hold<=ciphertext, s<=ciphertext^rk10, rnd<=9, go to DEC.
  - start in READY, including a cycle where in_valid is also high: start wins, the block is not accepted, re-key to KEXP.
- DEC:
  - Edges A+1..A+9: s <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(s)), rk[rnd])), rnd decrements 9..1.
  - Edge A+10: final round without InvMixColumns using rk0. plain_text <= result^chain, chain <= ct_hold, go to OUT.
  - out_valid=1 from cycle A+11, so latency is exactly 11 cycles from accept.
- OUT:
  - out_valid=1; plain_text_* held stable until out_ready.
  - out_valid&out_ready -> READY; out_valid=0 and in_ready=1 next cycle.
  - Minimum block period is 12 cycles; no overlap of blocks.
- start and in_valid are ignored in DEC and OUT.
- The chain register persists across blocks until the next start or reset (multi-block CBC message).
- S-box and inverse S-box use the team's shared lookup modules. Key expansion uses 4 S-box instances; DEC uses 16 inverse S-box instances.
- plain_text_* holds its last value after handshake; it is only meaningful when out_valid=1.

Test Plan:
1. Single block (SP800-38A F.2.2): key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, ct 7649abac8119b246cee98e9b12e9197d -> pt 6bc1bee22e409f96e93d7e117393172a. in_ready at start+11; out_valid exactly 11 cycles after accept.
2. Chaining: after test 1, ct 5086cb9b507219ee95db113a917678b2 -> pt ae2d8a571e03ac9c9eb76fac45af8e51 with no re-start. Re-issue start with the same IV and send ct2 alone -> pt differs, proving the chain was reset to the IV.
3. Backpressure: out_ready held low 20 cycles -> out_valid stays 1 and plain_text_* stable. in_ready stays 0 and in_valid pulses are ignored. The release cycle completes the handshake, and in_ready=1 next cycle.
4. Simultaneous start+in_valid in READY -> block not taken and state=KEXP. The block is then accepted at start+11 and decrypted with the new key/IV.
5. Reset asserted mid-DEC (cycle A+5) -> next cycle all outputs 0 and state IDLE. in_valid is then ignored until start; a fresh test 1 passes afterwards.
6. start pulsed during KEXP and DEC -> no effect. Output and timing identical to test 1.

Source files
------------

// File: rtl/aes128_cbc_dec_core.sv
// aes128_cbc_dec_core: iterative AES-128 CBC decryptor.
// Expands the 11 round keys on start, then runs one inverse round per clock
// and XORs the result with the chaining value to produce plaintext.
// The S-box lookups are shared GF(2^8)-inverse-plus-affine modules.

// GF(2^8) multiplicative inverse (x^254, with 0 mapping to 0)
module aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;

  // Square-and-multiply chain: 254 = 240 + 12 + 2
  assign x2   = gf_mul(a, a);
  assign x3   = gf_mul(x2, a);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign y    = gf_mul(x252, x2);
endmodule

// Forward S-box: inverse followed by the affine transform
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] inv;

  aes_gf_inv u_inv (.a(a), .y(inv));

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] pre;

  assign pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a(pre), .y(y));
endmodule

module aes128_cbc_dec_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] key_0,
  input  logic [31:0] key_1,
  input  logic [31:0] key_2,
  input  logic [31:0] key_3,
  input  logic [31:0] vector_0,
  input  logic [31:0] vector_1,
  input  logic [31:0] vector_2,
  input  logic [31:0] vector_3,
  input  logic [31:0] cipher_text_0,
  input  logic [31:0] cipher_text_1,
  input  logic [31:0] cipher_text_2,
  input  logic [31:0] cipher_text_3,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] plain_text_0,
  output logic [31:0] plain_text_1,
  output logic [31:0] plain_text_2,
  output logic [31:0] plain_text_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. The producer holds valid and data stable until that edge;
  // ready never depends combinationally on valid (both come from state only).

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    READY = 3'd2,
    DEC   = 3'd3,
    OUT   = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  logic [3:0]   rcnt_q, rcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] s_q, s_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] pt_q, pt_d;

  logic [127:0] key_w, iv_w, ct_w;
  assign key_w = {key_3, key_2, key_1, key_0};
  assign iv_w  = {vector_3, vector_2, vector_1, vector_0};
  assign ct_w  = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
            mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
            mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
            mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
  endfunction

  // Byte r+4c sits at row r, column c; row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  // Key expansion: next round key from the previous one
  logic [3:0]   kidx;
  logic [127:0] rk_prev;
  logic [31:0]  rot_w, sub_w, temp_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_next;

  assign kidx    = (rcnt_q == 4'd0) ? 4'd0 : rcnt_q - 4'd1;
  assign rk_prev = rk_q[kidx];
  assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot_w[31-8*g -: 8]), .y(sub_w[31-8*g -: 8]));
  end

  assign temp_w  = sub_w ^ {rcon(rcnt_q), 24'h000000};
  assign n0      = rk_prev[127:96] ^ temp_w;
  assign n1      = rk_prev[95:64] ^ n0;
  assign n2      = rk_prev[63:32] ^ n1;
  assign n3      = rk_prev[31:0] ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  // Inverse round datapath on the running state
  logic [127:0] isr, isb, ark, imc;

  assign isr = inv_shift_rows(s_q);

  for (genvar g = 0; g < 16; g++) begin : g_isbox
    aes_inv_sbox u_isbox (.a(isr[127-8*g -: 8]), .y(isb[127-8*g -: 8]));
  end

  assign ark = isb ^ rk_q[rnd_q];
  assign imc = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                inv_mix_col(ark[63:32]), inv_mix_col(ark[31:0])};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start outranks in_valid in READY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KEXP;
      KEXP:    if (rcnt_q == 4'd10) state_d = READY;
      READY:   if (start) state_d = KEXP;
               else if (in_valid) state_d = DEC;
      DEC:     if (rnd_q == 4'd0) state_d = OUT;
      OUT:     if (out_ready) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      READY:     in_ready = 1'b1;
      KEXP, DEC: busy = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values: key capture/expansion, block accept, rounds
  always_comb begin
    rk_d    = rk_q;
    rcnt_d  = rcnt_q;
    rnd_d   = rnd_q;
    s_d     = s_q;
    ct_d    = ct_q;
    chain_d = chain_q;
    pt_d    = pt_q;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          rk_d[0] = key_w;
          chain_d = iv_w;
          rcnt_d  = 4'd1;
        end else if (state_q == READY && in_valid) begin
          ct_d  = ct_w;
          s_d   = ct_w ^ rk_q[10];
          rnd_d = 4'd9;
        end
      end
      KEXP: begin
        rk_d[rcnt_q] = rk_next;
        rcnt_d       = rcnt_q + 4'd1;
      end
      DEC: begin
        if (rnd_q != 4'd0) begin
          s_d   = imc;
          rnd_d = rnd_q - 4'd1;
        end else begin
          pt_d    = ark ^ chain_q;
          chain_d = ct_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      rcnt_q  <= '0;
      rnd_q   <= '0;
      s_q     <= '0;
      ct_q    <= '0;
      chain_q <= '0;
      pt_q    <= '0;
    end else begin
      rk_q    <= rk_d;
      rcnt_q  <= rcnt_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      ct_q    <= ct_d;
      chain_q <= chain_d;
      pt_q    <= pt_d;
    end
  end

  assign plain_text_0 = pt_q[31:0];
  assign plain_text_1 = pt_q[63:32];
  assign plain_text_2 = pt_q[95:64];
  assign plain_text_3 = pt_q[127:96];
endmodule

// File: tb/tb_aes128_cbc_dec_core.sv
// Bench for aes128_cbc_dec_core: known-answer CBC vectors plus random
// messages checked against a byte-level AES inverse-cipher model.
module tb_aes128_cbc_dec_core;
  logic         clk = 1'b0;
  logic         reset, start, in_valid, out_ready;
  logic [127:0] key_r, iv_r, ct_r;
  logic [31:0]  plain_text_0, plain_text_1, plain_text_2, plain_text_3;
  logic         in_ready, out_valid, busy;
  logic [127:0] pt_w;

  assign pt_w = {plain_text_3, plain_text_2, plain_text_1, plain_text_0};

  aes128_cbc_dec_core dut (
    .clk(clk), .reset(reset), .start(start),
    .key_0(key_r[31:0]), .key_1(key_r[63:32]), .key_2(key_r[95:64]), .key_3(key_r[127:96]),
    .vector_0(iv_r[31:0]), .vector_1(iv_r[63:32]), .vector_2(iv_r[95:64]), .vector_3(iv_r[127:96]),
    .cipher_text_0(ct_r[31:0]), .cipher_text_1(ct_r[63:32]),
    .cipher_text_2(ct_r[95:64]), .cipher_text_3(ct_r[127:96]),
    .in_valid(in_valid), .in_ready(in_ready),
    .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
    .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  logic [127:0] m_key, m_chain;
  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [7:0]   c63 = 8'h63;
  logic [7:0]   imc_k [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] aes_dec_model(input logic [127:0] k, input logic [127:0] c);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   col [4];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = c[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      // ShiftRows took column (c+row) into c; put each byte back
      for (int row = 0; row < 4; row++)
        for (int cl = 0; cl < 4; cl++) tmp[row + 4*((cl+row)%4)] = st[row + 4*cl];
      for (int i = 0; i < 16; i++) st[i] = isbox_t[tmp[i]] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      if (r > 0) begin
        for (int cl = 0; cl < 4; cl++) begin
          for (int row = 0; row < 4; row++) col[row] = st[row + 4*cl];
          for (int row = 0; row < 4; row++) begin
            st[row + 4*cl] = 8'h00;
            for (int j = 0; j < 4; j++)
              st[row + 4*cl] = st[row + 4*cl] ^ gmul(col[j], imc_k[(j - row + 4) % 4]);
          end
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic do_start(input logic [127:0] k, input logic [127:0] iv, input bit noise);
    int cnt;
    key_r = k;
    iv_r  = iv;
    start = 1'b1;
    m_key   = k;
    m_chain = iv;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    check_eq("kexp_flags", 128'({in_ready, out_valid, busy}), 128'(3'b001));
    while (!in_ready && cnt < 40) begin
      start = noise && (cnt == 3 || cnt == 6);
      if (start) begin
        key_r = rand128();
        iv_r  = rand128();
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check_eq("kexp_latency", 128'(cnt), 128'd11);
  endtask

  task automatic send_block(input logic [127:0] ct, input int hold, input bit noise,
                            output logic [127:0] got);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    ct_r     = ct;
    in_valid = 1'b1;
    exp_q.push_back(aes_dec_model(m_key, ct) ^ m_chain);
    m_chain = ct;
    @(negedge clk);
    in_valid = 1'b0;
    ct_r = rand128();
    cnt = 1;
    while (!out_valid && cnt < 40) begin
      start = noise && (cnt == 2 || cnt == 7);
      if (start) begin
        key_r = rand128();
        iv_r  = rand128();
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check_eq("dec_latency", 128'(cnt), 128'd11);
    got = pt_w;
    if (exp_q.size() > 0) check_eq("plaintext", pt_w, exp_q.pop_front());
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      ct_r = rand128();
      @(negedge clk);
      check_eq("bp_flags", 128'({out_valid, in_ready}), 128'(2'b10));
      check_eq("bp_stable", pt_w, got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_handshake", 128'({in_ready, out_valid}), 128'(2'b10));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] got;
    logic [127:0] k2, iv2, c4;
    int cnt;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key_r = '0;
    iv_r = '0;
    ct_r = '0;
    build_tables();
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 128'({in_ready, out_valid, busy}), 128'd0);
    check_eq("reset_pt", pt_w, 128'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_flags", 128'({in_ready, out_valid, busy}), 128'd0);

    // Single block known answer, then chained second block
    do_start(K1, IV1, 1'b0);
    send_block(C1, 0, 1'b0, got);
    check_eq("kat_block1", got, P1);
    send_block(C2, 0, 1'b0, got);
    check_eq("kat_block2_chain", got, P2);

    // Re-start restores the IV as chain
    do_start(K1, IV1, 1'b0);
    send_block(C2, 0, 1'b0, got);
    check_eq("restart_differs", 128'(got != P2), 128'd1);

    // Backpressure with ignored in_valid pulses
    send_block(C1, 20, 1'b0, got);
    send_block(C2, 0, 1'b0, got);

    // start together with in_valid in READY: re-key wins
    k2  = rand128();
    iv2 = rand128();
    c4  = rand128();
    key_r = k2;
    iv_r  = iv2;
    ct_r  = c4;
    start = 1'b1;
    in_valid = 1'b1;
    m_key   = k2;
    m_chain = iv2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    cnt = 1;
    seen = 1'b0;
    while (!in_ready && cnt < 40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check_eq("start_wins_latency", 128'(cnt), 128'd11);
    check_eq("start_wins_no_output", 128'(seen), 128'd0);
    send_block(c4, 0, 1'b0, got);

    // Reset in the middle of a decryption
    ct_r = C1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_dec_busy", 128'({in_ready, out_valid, busy}), 128'(3'b001));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_flags", 128'({in_ready, out_valid, busy}), 128'd0);
    check_eq("abort_pt", pt_w, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      ct_r = rand128();
      @(negedge clk);
      if (in_ready || out_valid || busy) seen = 1'b1;
    end
    in_valid = 1'b0;
    check_eq("idle_ignores_in_valid", 128'(seen), 128'd0);
    do_start(K1, IV1, 1'b0);
    send_block(C1, 0, 1'b0, got);
    check_eq("kat_after_reset", got, P1);

    // start pulses during KEXP and DEC have no effect
    do_start(K1, IV1, 1'b1);
    send_block(C1, 0, 1'b1, got);
    check_eq("kat_start_noise", got, P1);

    // Random multi-block messages
    for (int m = 0; m < 15; m++) begin
      do_start(rand128(), rand128(), 1'b0);
      for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_block(rand128(), int'($urandom_range(0, 3)), 1'b0, got);
      end
    end

    check_eq("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
